// File: rtl/compare_pkg.sv
// compare_pkg: shared constants and elaboration helpers for the pipelined comparator.
//   Mode*        - MODE encodings driven on compare_pipe.MODE
//   calc_stages  - pipeline depth for a given operand width and slice width
//   last_chunk   - width of the final (possibly narrower) slice
//   bus_offset   - bit offset of stage k's operand field in the packed operand bus
package compare_pkg;

  localparam logic [2:0] ModeEq  = 3'd0;
  localparam logic [2:0] ModeNe  = 3'd1;
  localparam logic [2:0] ModeUlt = 3'd2;
  localparam logic [2:0] ModeUle = 3'd3;
  localparam logic [2:0] ModeUgt = 3'd4;
  localparam logic [2:0] ModeUge = 3'd5;
  localparam logic [2:0] ModeSlt = 3'd6;
  localparam logic [2:0] ModeSle = 3'd7;

  function automatic int unsigned calc_stages(input int unsigned width, input int unsigned chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  function automatic int unsigned last_chunk(input int unsigned width, input int unsigned chunk);
    return width - (calc_stages(width, chunk) - 1) * chunk;
  endfunction

  // Stage k consumes an operand field of width - k*chunk bits; fields are packed LSB first.
  function automatic int unsigned bus_offset(input int unsigned width, input int unsigned chunk,
                                             input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned j = 0; j < k; j++) begin
      off += width - j * chunk;
    end
    return off;
  endfunction

endpackage

// File: rtl/compare_stage.sv
// compare_stage: one slice of the B + ~A + 1 carry chain with its pipeline register.
//   clk, rst_n          - clock, asynchronous active-low reset
//   up_valid/up_ready   - upstream handshake (up_ready depends only on v_q and dn_ready)
//   a, b                - not-yet-consumed operand bits; the low SliceW bits are resolved here
//   carry, eq, mode     - running carry, running equality and mode from the previous stage
//   dn_valid/dn_ready   - downstream handshake
//   q_carry, q_eq, q_mode, q_a, q_b - registered results and the remaining upper operand bits
module compare_stage #(
  parameter int unsigned InW    = 4,
  parameter int unsigned SliceW = 4,
  localparam int unsigned RemW  = (InW > SliceW) ? InW - SliceW : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [InW-1:0]    a,
  input  logic [InW-1:0]    b,
  input  logic              carry,
  input  logic              eq,
  input  logic [2:0]        mode,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic              q_carry,
  output logic              q_eq,
  output logic [2:0]        q_mode,
  output logic [RemW-1:0]   q_a,
  output logic [RemW-1:0]   q_b
);

  logic [SliceW-1:0] a_s, b_s, diff_unused;
  logic              carry_d, eq_d, load, v_q;
  logic [RemW-1:0]   a_rem_d, b_rem_d;

  assign a_s = a[SliceW-1:0];
  assign b_s = b[SliceW-1:0];

  // Only the carry-out of the slice matters; the difference bits are discarded.
  assign {carry_d, diff_unused} = {1'b0, b_s} + {1'b0, ~a_s} + (SliceW + 1)'(carry);
  assign eq_d = eq & (a_s == b_s);

  if (InW > SliceW) begin : g_rem
    assign a_rem_d = a[InW-1:SliceW];
    assign b_rem_d = b[InW-1:SliceW];
  end else begin : g_no_rem
    assign a_rem_d = '0;
    assign b_rem_d = '0;
  end

  assign up_ready = ~v_q | dn_ready;
  assign load     = up_valid & up_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= 1'b0;
      q_carry <= 1'b0;
      q_eq    <= 1'b0;
      q_mode  <= '0;
      q_a     <= '0;
      q_b     <= '0;
    end else begin
      if (up_ready) begin
        v_q <= up_valid;
      end
      if (load) begin
        q_carry <= carry_d;
        q_eq    <= eq_d;
        q_mode  <= mode;
        q_a     <= a_rem_d;
        q_b     <= b_rem_d;
      end
    end
  end

  assign dn_valid = v_q;

endmodule

// File: rtl/compare_pipe.sv
// compare_pipe: pipelined multi-mode integer comparator, one CHUNK-bit slice per stage.
//   CLK, RESETN          - clock, asynchronous active-low reset
//   I0 (A), I1 (B), MODE - operands and operation (EQ NE ULT ULE UGT UGE SLT SLE)
//   VALID_IN/READY_IN    - input handshake
//   O, EQ, COUT          - A op B, A == B, carry of B + ~A + 1 (B >= A)
//   VALID_OUT/READY_OUT  - output handshake
module compare_pipe
  import compare_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [2:0]       MODE,
  input  logic             VALID_IN,
  output logic             READY_IN,
  output logic             O,
  output logic             EQ,
  output logic             COUT,
  output logic             VALID_OUT,
  input  logic             READY_OUT
);

  localparam int unsigned STAGES = calc_stages(WIDTH, CHUNK);
  localparam int unsigned BusW   = bus_offset(WIDTH, CHUNK, STAGES);
  localparam logic [WIDTH-1:0] MsbMask = WIDTH'(64'd1 << (WIDTH - 1));

  logic              signed_mode;
  logic [BusW-1:0]   a_bus, b_bus;
  logic [STAGES:0]   v, rdy, carry, eq;
  logic [2:0]        mode [STAGES+1];
  logic              res;

  // Flipping both MSBs maps two's complement order onto unsigned order.
  assign signed_mode      = (MODE == ModeSlt) || (MODE == ModeSle);
  assign a_bus[WIDTH-1:0] = I0 ^ (signed_mode ? MsbMask : '0);
  assign b_bus[WIDTH-1:0] = I1 ^ (signed_mode ? MsbMask : '0);

  assign v[0]        = VALID_IN;
  assign carry[0]    = 1'b1;
  assign eq[0]       = 1'b1;
  assign mode[0]     = MODE;
  assign rdy[STAGES] = READY_OUT;
  assign READY_IN    = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned InW    = WIDTH - k * CHUNK;
    localparam int unsigned SliceW = (InW > CHUNK) ? CHUNK : InW;
    localparam int unsigned RemW   = (InW > SliceW) ? InW - SliceW : 1;
    localparam int unsigned Off    = bus_offset(WIDTH, CHUNK, k);

    logic [RemW-1:0] a_nxt, b_nxt;

    compare_stage #(
      .InW    (InW),
      .SliceW (SliceW)
    ) u_stage (
      .clk      (CLK),
      .rst_n    (RESETN),
      .up_valid (v[k]),
      .up_ready (rdy[k]),
      .a        (a_bus[Off +: InW]),
      .b        (b_bus[Off +: InW]),
      .carry    (carry[k]),
      .eq       (eq[k]),
      .mode     (mode[k]),
      .dn_valid (v[k+1]),
      .dn_ready (rdy[k+1]),
      .q_carry  (carry[k+1]),
      .q_eq     (eq[k+1]),
      .q_mode   (mode[k+1]),
      .q_a      (a_nxt),
      .q_b      (b_nxt)
    );

    if (k + 1 < STAGES) begin : g_fwd
      assign a_bus[bus_offset(WIDTH, CHUNK, k + 1) +: RemW] = a_nxt;
      assign b_bus[bus_offset(WIDTH, CHUNK, k + 1) +: RemW] = b_nxt;
    end else begin : g_end
      // The last stage has no upper bits left to forward.
      logic unused_rem;
      assign unused_rem = ^{a_nxt, b_nxt};
    end
  end

  always_comb begin
    res = 1'b0;
    case (mode[STAGES])
      ModeEq:           res = eq[STAGES];
      ModeNe:           res = ~eq[STAGES];
      ModeUlt, ModeSlt: res = carry[STAGES] & ~eq[STAGES];
      ModeUle, ModeSle: res = carry[STAGES];
      ModeUgt:          res = ~carry[STAGES];
      ModeUge:          res = ~carry[STAGES] | eq[STAGES];
      default:          res = 1'b0;
    endcase
  end

  // Gated by valid so an empty output stage always presents zeros.
  assign VALID_OUT = v[STAGES];
  assign O         = v[STAGES] & res;
  assign EQ        = v[STAGES] & eq[STAGES];
  assign COUT      = v[STAGES] & carry[STAGES];

endmodule

// File: tb/tb_compare_pipe.sv
module tb_compare_pipe;

  localparam int STAGES = 4;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [15:0] I0, I1;
  logic [2:0]  MODE;
  logic        VALID_IN, READY_IN, O, EQ, COUT, VALID_OUT, READY_OUT;

  typedef struct {
    logic o;
    logic eq;
    logic c;
    int   t;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;

  compare_pipe #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .I0        (I0),
    .I1        (I1),
    .MODE      (MODE),
    .VALID_IN  (VALID_IN),
    .READY_IN  (READY_IN),
    .O         (O),
    .EQ        (EQ),
    .COUT      (COUT),
    .VALID_OUT (VALID_OUT),
    .READY_OUT (READY_OUT)
  );

  always #5 CLK = ~CLK;

  // Reference: direct arithmetic comparison of A=I0 against B=I1.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] m);
    exp_t r;
    logic s;
    s    = (m == 3'd6) || (m == 3'd7);
    r.eq = (a == b);
    r.c  = s ? ($signed(b) >= $signed(a)) : (b >= a);
    case (m)
      3'd0:    r.o = (a == b);
      3'd1:    r.o = (a != b);
      3'd2:    r.o = (a < b);
      3'd3:    r.o = (a <= b);
      3'd4:    r.o = (a > b);
      3'd5:    r.o = (a >= b);
      3'd6:    r.o = ($signed(a) < $signed(b));
      default: r.o = ($signed(a) <= $signed(b));
    endcase
    r.t = 0;
    return r;
  endfunction

  function automatic logic [15:0] rnd_b(input logic [15:0] a);
    int unsigned sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return a;
    if (sel == 1) return a ^ (16'h1 << $urandom_range(0, 15));
    return 16'($urandom);
  endfunction

  // Drive one cycle's inputs after the falling edge and sample just after.
  task automatic tick(input logic vin, input logic [15:0] a, input logic [15:0] b,
                      input logic [2:0] m, input logic rout, output logic acc, output logic vo);
    @(negedge CLK);
    VALID_IN  = vin;
    I0        = a;
    I1        = b;
    MODE      = m;
    READY_OUT = rout;
    #1;
    acc = vin & READY_IN;
    vo  = VALID_OUT;
    cyc++;
  endtask

  task automatic test_reset();
    VALID_IN = 0; READY_OUT = 0; I0 = 0; I1 = 0; MODE = 0;
    RESETN = 1'b1;
    #3 RESETN = 1'b0;
    #1;
    tests_run++;
    if ({VALID_OUT, O, EQ, COUT} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_outputs: VALID_OUT/O/EQ/COUT=%b%b%b%b, expected 0000",
               VALID_OUT, O, EQ, COUT);
    end
    repeat (2) @(posedge CLK);
    #1 RESETN = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] ta [8] = '{16'h1234, 16'h1235, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                            16'h0FFF, 16'hF000};
    logic [15:0] tb [8] = '{16'h1234, 16'h1234, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
                            16'h1000, 16'hE000};
    logic [2:0]  tm [8] = '{3'd3, 3'd3, 3'd6, 3'd2, 3'd4, 3'd1, 3'd2, 3'd5};
    logic [2:0]  tx [8] = '{3'b111, 3'b000, 3'b101, 3'b000, 3'b100, 3'b100, 3'b101, 3'b100};
    logic acc, vo;
    exp_t e;
    for (int i = 0; i < 8 + STAGES + 2; i++) begin
      if (i < 8) begin
        tick(1'b1, ta[i], tb[i], tm[i], 1'b1, acc, vo);
        tests_run++;
        if (acc !== 1'b1) begin
          tests_failed++;
          $display("FAIL basic_accept[%0d]: accepted=%b, expected 1", i, acc);
        end
        if (acc) begin
          e.o = tx[i][2]; e.eq = tx[i][1]; e.c = tx[i][0]; e.t = cyc;
          sb.push_back(e);
        end
      end else begin
        tick(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc, vo);
      end
      if (vo) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL basic_extra_output: VALID_OUT=1, expected no pending result");
        end else begin
          e = sb.pop_front();
          if ({O, EQ, COUT} !== {e.o, e.eq, e.c} || (cyc - e.t) != STAGES) begin
            tests_failed++;
            $display("FAIL basic_result: O/EQ/COUT=%b%b%b latency=%0d, expected %b%b%b latency=%0d",
                     O, EQ, COUT, cyc - e.t, e.o, e.eq, e.c, STAGES);
          end
        end
      end
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_drain: %0d results missing, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_backpressure();
    logic acc, vo, have_snap;
    logic [3:0] snap;
    logic [15:0] a, b;
    logic [2:0] m;
    int accepts;
    exp_t e;
    accepts = 0;
    have_snap = 0;
    snap = '0;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); b = rnd_b(a); m = 3'($urandom_range(0, 7));
      tick(1'b1, a, b, m, 1'b0, acc, vo);
      if (acc) begin
        accepts++;
        sb.push_back(model(a, b, m));
      end
      if (vo && have_snap) begin
        tests_run++;
        if ({VALID_OUT, O, EQ, COUT} !== snap) begin
          tests_failed++;
          $display("FAIL bp_hold: VALID_OUT/O/EQ/COUT=%b, expected %b",
                   {VALID_OUT, O, EQ, COUT}, snap);
        end
      end else if (vo) begin
        snap = {VALID_OUT, O, EQ, COUT};
        have_snap = 1'b1;
      end
    end
    tests_run++;
    if (accepts != STAGES || READY_IN !== 1'b0 || VALID_OUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_fill: accepts=%0d READY_IN=%b VALID_OUT=%b, expected %0d 0 1",
               accepts, READY_IN, VALID_OUT, STAGES);
    end
    for (int i = 0; i < STAGES + 1; i++) begin
      tick(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc, vo);
      tests_run++;
      if (i == STAGES) begin
        if (vo !== 1'b0 || sb.size() != 0) begin
          tests_failed++;
          $display("FAIL bp_drain_end: VALID_OUT=%b pending=%0d, expected 0 0", vo, sb.size());
        end
      end else if (vo !== 1'b1 || sb.size() == 0) begin
        tests_failed++;
        $display("FAIL bp_drain[%0d]: VALID_OUT=%b, expected 1", i, vo);
      end else begin
        e = sb.pop_front();
        if ({O, EQ, COUT} !== {e.o, e.eq, e.c}) begin
          tests_failed++;
          $display("FAIL bp_result[%0d]: O/EQ/COUT=%b%b%b, expected %b%b%b",
                   i, O, EQ, COUT, e.o, e.eq, e.c);
        end
      end
    end
    sb.delete();
  endtask

  task automatic test_random();
    logic acc, vo, vin, rout;
    logic [15:0] a, b;
    logic [2:0] m;
    exp_t e;
    for (int i = 0; i < 340; i++) begin
      vin  = (i < 300) && ($urandom_range(0, 9) < 7);
      rout = (i >= 300) || ($urandom_range(0, 9) < 7);
      a = 16'($urandom); b = rnd_b(a); m = 3'($urandom_range(0, 7));
      tick(vin, a, b, m, rout, acc, vo);
      if (acc) sb.push_back(model(a, b, m));
      if (vo && rout) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_extra_output: VALID_OUT=1, expected no pending result");
        end else begin
          e = sb.pop_front();
          if ({O, EQ, COUT} !== {e.o, e.eq, e.c}) begin
            tests_failed++;
            $display("FAIL rand_result: O/EQ/COUT=%b%b%b, expected %b%b%b",
                     O, EQ, COUT, e.o, e.eq, e.c);
          end
        end
      end
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_drain: %0d results missing, expected 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    logic acc, vo, seen;
    logic [15:0] a, b;
    logic [2:0] m;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = rnd_b(a);
      tick(1'b1, a, b, 3'd3, 1'b1, acc, vo);
    end
    @(negedge CLK);
    VALID_IN = 1'b0;
    @(negedge CLK);
    #1;
    tests_run++;
    if (VALID_OUT !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre: VALID_OUT=%b, expected 1", VALID_OUT);
    end
    #2 RESETN = 1'b0;
    #1;
    tests_run++;
    if ({VALID_OUT, O, EQ, COUT} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_async: VALID_OUT/O/EQ/COUT=%b%b%b%b, expected 0000",
               VALID_OUT, O, EQ, COUT);
    end
    sb.delete();
    @(posedge CLK);
    #2 RESETN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc, vo);
      seen |= vo;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_stale: VALID_OUT seen=%b, expected 0", seen);
    end
    a = 16'($urandom); b = rnd_b(a); m = 3'($urandom_range(0, 7));
    tick(1'b1, a, b, m, 1'b1, acc, vo);
    e = model(a, b, m);
    e.t = cyc;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, acc, vo);
      seen = vo;
    end
    tests_run++;
    if (!seen || {O, EQ, COUT} !== {e.o, e.eq, e.c} || (cyc - e.t) != STAGES) begin
      tests_failed++;
      $display("FAIL rst_new: seen=%b O/EQ/COUT=%b%b%b latency=%0d, expected 1 %b%b%b %0d",
               seen, O, EQ, COUT, cyc - e.t, e.o, e.eq, e.c, STAGES);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/compare_pipe.md
Name: compare_pipe

Overview:
- Parametrised, pipelined, multi-mode integer comparator; successor to the fixed 2-bit unsigned less-or-equal block.
- Computes I1 + ~I0 + 1 as a carry chain split into CHUNK-bit slices, one slice per pipeline stage, so wide compares meet iCE40 timing.
- Runs one compare per cycle with valid/ready handshakes on both sides.
- Sits between datapath producers and control FSMs, e.g. threshold and limit checks.

Parameters:
- WIDTH, 16, operand width in bits; legal range 1..64.
- CHUNK, 4, bits resolved per pipeline stage; legal range 1..WIDTH.
- STAGES, derived as ceil(WIDTH/CHUNK), pipeline depth; not user-overridable.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESETN  input  1  asynchronous active-low reset.
- I0  input  WIDTH  left operand A.
- I1  input  WIDTH  right operand B.
- MODE  input  3  operation: 0 EQ, 1 NE, 2 ULT, 3 ULE, 4 UGT, 5 UGE, 6 SLT, 7 SLE.
- VALID_IN  input  1  I0/I1/MODE are valid.
- READY_IN  output  1  block can accept an input this cycle.
- O  output  1  result of "A op B".
- EQ  output  1  A == B, independent of MODE.
- COUT  output  1  final carry of B + ~A + 1 (1 means B >= A in the compared domain).
- VALID_OUT  output  1  O/EQ/COUT are valid.
- READY_OUT  input  1  downstream accepts the output.

Behaviour:
- Transfer rule: a transfer occurs when VALID and READY are both high on the same edge.
- Input transfer: when VALID_IN & READY_IN, the operands and MODE enter stage 0.
- Signed modes (6, 7): the MSB of both operands is inverted at entry; the datapath is otherwise unsigned.
- Stage k computes chunk k, LSB first, from:
  - the incoming carry (stage 0 uses 1),
  - the incoming equality flag (stage 0 uses 1).
- Stage k registers carry_k, eq_k and MODE, plus the not-yet-consumed upper operand bits.
- The last chunk is WIDTH - (STAGES-1)*CHUNK bits wide.
- Result decode at the final stage (c = final carry, e = final eq):
  - EQ: e
  - NE: !e
  - ULT/SLT: c & !e
  - ULE/SLE: c
  - UGT: !c
  - UGE: !c | e
- Latency: exactly STAGES cycles from input transfer to VALID_OUT, with READY_OUT held high. Throughput is 1 per cycle.
- Per-stage valid bit v_k:
  - stage k may load when !v_k or stage k+1 is loading; the last stage loads when !v_last or READY_OUT.
  - READY_IN = ready of stage 0, combinational from READY_OUT through the ready chain; there is no combinational path from VALID_IN to READY_IN.
- Backpressure:
  - With READY_OUT low, the pipeline fills and holds its data.
  - Once all STAGES slots are valid, READY_IN drops.
  - Bubbles collapse: while a downstream stage is empty, upstream stages keep advancing.
- Output hold: VALID_OUT/O/EQ/COUT stay stable while VALID_OUT & !READY_OUT.
- Simultaneous input and output transfer at the full state: allowed; occupancy is unchanged.
- Reset: RESETN low clears, immediately and asynchronously:
  - all v_k; VALID_OUT = 0, O = 0, EQ = 0, COUT = 0;
  - all data registers to 0.
  - In-flight compares are discarded.
- Reset release: first input transfer is possible on the first rising edge after RESETN goes high.
- STAGES = 1 (CHUNK >= WIDTH): single registered stage, latency 1.
- WIDTH = 1: UGT/ULT decode as in a 1-bit subtractor. In signed modes, 1 is the value -1.

Decomposition:
- Package compare_pkg:
  - MODE encodings as named constants;
  - a function computing STAGES from WIDTH/CHUNK;
  - a function computing last-chunk width.
- Sub-module compare_stage: one CHUNK-wide carry/equality slice plus its pipeline register and ready logic. It is parametrised by slice width and carries the remaining operand bits through.
- compare_pipe: generates STAGES instances, the signed MSB inversion and the final MODE decode.

Test Plan (WIDTH=16, CHUNK=4, STAGES=4):
- Back-to-back basic compares:
  - MODE=ULE, A=0x1234, B=0x1234, READY_OUT=1 -> 4 cycles later O=1, EQ=1, COUT=1.
  - Next cycle A=0x1235, B=0x1234 -> O=0, EQ=0, COUT=0.
- Signed vs unsigned: A=0x8000, B=0x0001:
  - SLT -> O=1; ULT -> O=0; UGT -> O=1; NE -> O=1.
  - Issued on 4 consecutive cycles, results appear on 4 consecutive cycles.
- Carry across slices: A=0x0FFF, B=0x1000, MODE=ULT -> O=1.
- Equality breaks only in top chunk: A=0xF000, B=0xE000, MODE=UGE -> O=1, EQ=0.
- Backpressure:
  - Hold READY_OUT=0 and drive VALID_IN every cycle -> READY_IN falls after exactly 4 accepts; VALID_OUT and its data stay stable.
  - Release READY_OUT -> 4 results drain in order, one per cycle, with no loss or duplication.
- Reset mid-flight: 3 compares in flight, pulse RESETN low asynchronously between edges -> VALID_OUT=0 immediately. After release, no stale results appear; a new compare returns after 4 cycles.
